// File: rtl/simple_pkg.sv
// ============================================================================
// simple_pkg : shared encodings for the SIMPLE core control path
// Rev 1.0    : initial release
// ============================================================================
`default_nettype none

package simple_pkg;

    localparam logic [2:0] PH_IDLE   = 3'd0;
    localparam logic [2:0] PH_FETCH  = 3'd1;
    localparam logic [2:0] PH_DECODE = 3'd2;
    localparam logic [2:0] PH_EXEC   = 3'd3;
    localparam logic [2:0] PH_MEM    = 3'd4;
    localparam logic [2:0] PH_WB     = 3'd5;

    localparam logic [1:0] SRC_A_RD    = 2'b00;
    localparam logic [1:0] SRC_A_IN    = 2'b01;
    localparam logic [1:0] SRC_A_PC    = 2'b10;
    localparam logic [1:0] SRC_A_ZERO  = 2'b11;

    localparam logic [1:0] SRC_B_SIMM8 = 2'b00;
    localparam logic [1:0] SRC_B_ZIMM4 = 2'b01;
    localparam logic [1:0] SRC_B_RS    = 2'b10;
    localparam logic [1:0] SRC_B_ZERO  = 2'b11;

    localparam logic [3:0] ALU_ADD         = 4'b0000;
    localparam logic [3:0] ALU_SUB         = 4'b0001;
    localparam logic [3:0] ALU_AND         = 4'b0010;
    localparam logic [3:0] ALU_OR          = 4'b0011;
    localparam logic [3:0] ALU_XOR         = 4'b0100;
    localparam logic [3:0] ALU_CMP         = 4'b0101;
    localparam logic [3:0] ALU_MOV         = 4'b0110;
    localparam logic [3:0] ALU_SHIFT_FIRST = 4'b1000;
    localparam logic [3:0] ALU_SHIFT_LAST  = 4'b1011;
    localparam logic [3:0] IO_IN           = 4'b1100;
    localparam logic [3:0] IO_OUT          = 4'b1101;
    localparam logic [3:0] IO_HLT          = 4'b1111;

    localparam logic [1:0] CLS_LD  = 2'b00;
    localparam logic [1:0] CLS_ST  = 2'b01;
    localparam logic [1:0] CLS_BR  = 2'b10;
    localparam logic [1:0] CLS_ALU = 2'b11;

    localparam logic [2:0] OP3_LI  = 3'b000;
    localparam logic [2:0] OP3_B   = 3'b100;
    localparam logic [2:0] OP3_BCC = 3'b111;

    localparam logic [2:0] CC_BE  = 3'b000;
    localparam logic [2:0] CC_BLT = 3'b001;
    localparam logic [2:0] CC_BLE = 3'b010;
    localparam logic [2:0] CC_BNE = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2,
        ST_PAUSE  = 2'd3
    } seq_state_t;

    function automatic logic branch_cond(input logic [2:0] cc, input logic s,
                                         input logic z, input logic v);
        logic taken;
        case (cc)
            CC_BE:   taken = z;
            CC_BLT:  taken = s ^ v;
            CC_BLE:  taken = z | (s ^ v);
            CC_BNE:  taken = ~z;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

`default_nettype wire

// File: rtl/instruction_decoder.sv
// ============================================================================
// instruction_decoder : combinational IR -> execute selects and class flags
// Rev 1.0             : initial release
// ============================================================================
`default_nettype none

module instruction_decoder
    import simple_pkg::*;
(
    input  logic [15:0] instruction_register,
    output logic [1:0]  op_alu_src_a,
    output logic [1:0]  op_alu_src_b,
    output logic [3:0]  op_alu,
    output logic        is_out,
    output logic        latch_flags,
    output logic        writes_reg,
    output logic        is_ld,
    output logic        is_st,
    output logic        is_hlt,
    output logic        is_b,
    output logic        is_bcc
);

    logic [3:0] op;
    logic       unused_ir_low;

    assign op            = instruction_register[7:4];
    assign unused_ir_low = ^instruction_register[3:0];

    // Anything not matched below falls through as a NOP: no writes, PC still advances.
    always_comb begin
        op_alu_src_a = SRC_A_ZERO;
        op_alu_src_b = SRC_B_ZERO;
        op_alu       = ALU_ADD;
        is_out       = 1'b0;
        latch_flags  = 1'b0;
        writes_reg   = 1'b0;
        is_ld        = 1'b0;
        is_st        = 1'b0;
        is_hlt       = 1'b0;
        is_b         = 1'b0;
        is_bcc       = 1'b0;
        case (instruction_register[15:14])
            CLS_ALU: begin
                if (op <= ALU_MOV) begin
                    op_alu_src_a = SRC_A_RD;
                    op_alu_src_b = SRC_B_RS;
                    op_alu       = op;
                    latch_flags  = 1'b1;
                    writes_reg   = (op != ALU_CMP);
                end else if (op >= ALU_SHIFT_FIRST && op <= ALU_SHIFT_LAST) begin
                    op_alu_src_a = SRC_A_RD;
                    op_alu_src_b = SRC_B_ZIMM4;
                    op_alu       = op;
                    latch_flags  = 1'b1;
                    writes_reg   = 1'b1;
                end else if (op == IO_IN) begin
                    op_alu_src_a = SRC_A_IN;
                    op_alu_src_b = SRC_B_ZERO;
                    writes_reg   = 1'b1;
                end else if (op == IO_OUT) begin
                    op_alu_src_a = SRC_A_RD;
                    is_out       = 1'b1;
                end else if (op == IO_HLT) begin
                    is_hlt       = 1'b1;
                end
            end
            CLS_LD, CLS_ST: begin
                op_alu_src_a = SRC_A_RD;
                op_alu_src_b = SRC_B_SIMM8;
                is_ld        = (instruction_register[15:14] == CLS_LD);
                is_st        = (instruction_register[15:14] == CLS_ST);
                writes_reg   = (instruction_register[15:14] == CLS_LD);
            end
            default: begin
                case (instruction_register[13:11])
                    OP3_LI: begin
                        op_alu_src_a = SRC_A_ZERO;
                        op_alu_src_b = SRC_B_SIMM8;
                        writes_reg   = 1'b1;
                    end
                    OP3_B: begin
                        op_alu_src_a = SRC_A_PC;
                        op_alu_src_b = SRC_B_SIMM8;
                        is_b         = 1'b1;
                    end
                    OP3_BCC: begin
                        op_alu_src_a = SRC_A_PC;
                        op_alu_src_b = SRC_B_SIMM8;
                        is_bcc       = (instruction_register[10:8] <= CC_BNE);
                    end
                    default: ;
                endcase
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/phase_sequencer.sv
// ============================================================================
// phase_sequencer : five-phase instruction cycle, run/stop/halt and flag latch
// Optional single-step mode: define PHASE_SEQUENCER_STEP_EN
// Rev 1.0         : initial release
// ============================================================================
`default_nettype none

module phase_sequencer
    import simple_pkg::*;
#(
    parameter int PHASES = 5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic        step,
    input  logic [15:0] instruction_register,
    input  logic [3:0]  cond,
    output logic [2:0]  phase_counter,
    output logic [1:0]  op_alu_src_a,
    output logic [1:0]  op_alu_src_b,
    output logic [3:0]  op_alu,
    output logic        op_data_for_output_update,
    output logic        ir_load,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        pc_update,
    output logic        branch_taken,
    output logic [3:0]  flags,
    output logic        running,
    output logic        halted
);

`ifdef PHASE_SEQUENCER_STEP_EN
    localparam logic STEP_EN = 1'b1;
`else
    localparam logic STEP_EN = 1'b0;
`endif

    localparam logic [2:0] LAST_PHASE = 3'(PHASES);

    seq_state_t state_q, state_d;
    logic [2:0] phase_q, phase_d;
    logic [3:0] flags_q, flags_d;
    logic       halted_q, halted_d;
    logic       stop_pending_q, stop_pending_d;
    logic       step_seen_q, step_seen_d;

    logic latch_flags, writes_reg, is_ld, is_st, is_hlt, is_b, is_bcc;
    logic go, live, last, bcc_hit;

    instruction_decoder u_decoder (
        .instruction_register (instruction_register),
        .op_alu_src_a         (op_alu_src_a),
        .op_alu_src_b         (op_alu_src_b),
        .op_alu               (op_alu),
        .is_out               (op_data_for_output_update),
        .latch_flags          (latch_flags),
        .writes_reg           (writes_reg),
        .is_ld                (is_ld),
        .is_st                (is_st),
        .is_hlt               (is_hlt),
        .is_b                 (is_b),
        .is_bcc               (is_bcc)
    );

    // stop beats a simultaneous start everywhere
    assign go   = start && !stop;
    assign last = (phase_q == LAST_PHASE);

    always_comb begin
        state_d        = state_q;
        phase_d        = phase_q;
        flags_d        = flags_q;
        halted_d       = halted_q;
        stop_pending_d = stop_pending_q;
        step_seen_d    = STEP_EN && (go ? 1'b0 : (step_seen_q || step));
        case (state_q)
            ST_IDLE, ST_HALTED: begin
                if (go) begin
                    state_d  = ST_RUN;
                    phase_d  = PH_FETCH;
                    halted_d = 1'b0;
                end
            end
            ST_RUN: begin
                stop_pending_d = stop_pending_q || stop;
                if (phase_q == PH_EXEC && latch_flags) begin
                    flags_d = cond;
                end
                if (last) begin
                    phase_d = PH_FETCH;
                    if (is_hlt) begin
                        state_d        = ST_HALTED;
                        phase_d        = PH_IDLE;
                        halted_d       = 1'b1;
                        stop_pending_d = 1'b0;
                    end else if (stop_pending_d) begin
                        state_d        = ST_IDLE;
                        phase_d        = PH_IDLE;
                        stop_pending_d = 1'b0;
                    end else if (step_seen_d) begin
                        state_d = ST_PAUSE;
                        phase_d = PH_IDLE;
                    end
                end else begin
                    phase_d = phase_q + 3'd1;
                end
            end
            ST_PAUSE: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (start || (STEP_EN && step)) begin
                    state_d = ST_RUN;
                    phase_d = PH_FETCH;
                end
            end
            default: begin
                state_d = ST_IDLE;
                phase_d = PH_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            phase_q        <= PH_IDLE;
            flags_q        <= 4'b0000;
            halted_q       <= 1'b0;
            stop_pending_q <= 1'b0;
            step_seen_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            phase_q        <= phase_d;
            flags_q        <= flags_d;
            halted_q       <= halted_d;
            stop_pending_q <= stop_pending_d;
            step_seen_q    <= step_seen_d;
        end
    end

    // Strobes are masked during the reset cycle, even mid-instruction.
    assign live    = reset && (phase_q != PH_IDLE);
    assign bcc_hit = is_bcc && branch_cond(instruction_register[10:8], flags_q[3],
                                           flags_q[2], flags_q[0]);

    assign ir_load       = live && (phase_q == PH_FETCH);
    assign mem_read      = live && (phase_q == PH_MEM) && is_ld;
    assign mem_write     = live && (phase_q == PH_MEM) && is_st;
    assign reg_write     = live && last && writes_reg;
    assign pc_update     = live && last && !is_hlt;
    assign branch_taken  = live && last && (is_b || bcc_hit);

    assign phase_counter = phase_q;
    assign flags         = flags_q;
    assign running       = (phase_q != PH_IDLE);
    assign halted        = halted_q;

endmodule

`default_nettype wire

// File: tb/tb_phase_sequencer.sv
// ============================================================================
// tb_phase_sequencer : directed + random checks of phase_sequencer against a
// behavioural model; honours PHASE_SEQUENCER_STEP_EN when defined.
// Rev 1.0            : initial release
// ============================================================================
`default_nettype none

module tb_phase_sequencer;

`ifdef PHASE_SEQUENCER_STEP_EN
    localparam bit STEP_EN = 1'b1;
`else
    localparam bit STEP_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset, start, stop, step;
    logic [15:0] instruction_register;
    logic [3:0]  cond;
    logic [2:0]  phase_counter;
    logic [1:0]  op_alu_src_a, op_alu_src_b;
    logic [3:0]  op_alu, flags;
    logic        op_data_for_output_update, ir_load, reg_write, mem_read;
    logic        mem_write, pc_update, branch_taken, running, halted;

    always #5 clock = ~clock;

    phase_sequencer #(.PHASES(5)) dut (
        .clock                     (clock),
        .reset                     (reset),
        .start                     (start),
        .stop                      (stop),
        .step                      (step),
        .instruction_register      (instruction_register),
        .cond                      (cond),
        .phase_counter             (phase_counter),
        .op_alu_src_a              (op_alu_src_a),
        .op_alu_src_b              (op_alu_src_b),
        .op_alu                    (op_alu),
        .op_data_for_output_update (op_data_for_output_update),
        .ir_load                   (ir_load),
        .reg_write                 (reg_write),
        .mem_read                  (mem_read),
        .mem_write                 (mem_write),
        .pc_update                 (pc_update),
        .branch_taken              (branch_taken),
        .flags                     (flags),
        .running                   (running),
        .halted                    (halted)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // What the instruction means, read straight off the encoding tables.
    typedef struct {
        bit         ab_def;
        bit         alu_def;
        logic [1:0] a;
        logic [1:0] b;
        logic [3:0] alu;
        bit         out;
        bit         setflags;
        bit         wr;
        bit         ld;
        bit         st;
        bit         hlt;
        bit         br;
        int         cc;
    } ref_dec_t;

    function automatic ref_dec_t ref_decode(input logic [15:0] ir);
        ref_dec_t d;
        int cls, op, op3;
        d = '{default: 0};
        d.cc = -1;
        cls = int'(ir[15:14]);
        op  = int'(ir[7:4]);
        op3 = int'(ir[13:11]);
        if (cls == 3) begin
            if (op <= 6) begin
                d.ab_def = 1; d.alu_def = 1; d.a = 2'd0; d.b = 2'd2; d.alu = 4'(op);
                d.setflags = 1; d.wr = (op != 5);
            end else if (op >= 8 && op <= 11) begin
                d.ab_def = 1; d.a = 2'd0; d.b = 2'd1; d.setflags = 1; d.wr = 1;
            end else if (op == 12) begin
                d.ab_def = 1; d.alu_def = 1; d.a = 2'd1; d.b = 2'd3; d.alu = 4'd0; d.wr = 1;
            end else if (op == 13) begin
                d.out = 1;
            end else if (op == 15) begin
                d.hlt = 1;
            end
        end else if (cls <= 1) begin
            d.ab_def = 1; d.alu_def = 1; d.a = 2'd0; d.b = 2'd0; d.alu = 4'd0;
            d.ld = (cls == 0); d.st = (cls == 1); d.wr = (cls == 0);
        end else if (op3 == 0) begin
            d.ab_def = 1; d.a = 2'd3; d.b = 2'd0; d.wr = 1;
        end else if (op3 == 4) begin
            d.ab_def = 1; d.a = 2'd2; d.b = 2'd0; d.br = 1;
        end else if (op3 == 7 && int'(ir[10:8]) <= 3) begin
            d.cc = int'(ir[10:8]);
        end
        return d;
    endfunction

    function automatic bit ref_taken(input int cc, input logic [3:0] f);
        bit s, z, v;
        s = f[3]; z = f[2]; v = f[0];
        case (cc)
            0:       return z;
            1:       return s != v;
            2:       return z || (s != v);
            3:       return !z;
            default: return 0;
        endcase
    endfunction

    // Model: which phase of the current instruction we are in (0 = not executing)
    int         m_phase    = 0;
    bit         m_halted   = 0;
    bit         m_paused   = 0;
    bit         m_pending  = 0;
    bit         m_stepping = 0;
    logic [3:0] m_flags    = 4'h0;

    task automatic cycle(input bit rn, input bit st, input bit sp, input bit stp,
                         input logic [15:0] ir, input logic [3:0] c);
        ref_dec_t   d;
        bit         live, go;
        logic [5:0] exp_str;
        @(negedge clock);
        reset = rn; start = st; stop = sp; step = stp;
        instruction_register = ir; cond = c;
        #1;
        d    = ref_decode(ir);
        live = rn && (m_phase != 0);
        exp_str = {live && m_phase == 1,
                   live && m_phase == 5 && d.wr,
                   live && m_phase == 4 && d.ld,
                   live && m_phase == 4 && d.st,
                   live && m_phase == 5 && !d.hlt,
                   live && m_phase == 5 && (d.br || ref_taken(d.cc, m_flags))};
        check_eq("phase", 16'(phase_counter), 16'(m_phase));
        check_eq("running", 16'(running), 16'(m_phase != 0));
        check_eq("halted", 16'(halted), 16'(m_halted));
        check_eq("flags", 16'(flags), 16'(m_flags));
        check_eq("strobes", 16'({ir_load, reg_write, mem_read, mem_write, pc_update, branch_taken}),
                 16'(exp_str));
        check_eq("out_dec", 16'(op_data_for_output_update), 16'(d.out));
        if (d.ab_def)  check_eq("src_ab", 16'({op_alu_src_a, op_alu_src_b}), 16'({d.a, d.b}));
        if (d.alu_def) check_eq("op_alu", 16'(op_alu), 16'(d.alu));

        if (!rn) begin
            m_phase = 0; m_halted = 0; m_paused = 0; m_pending = 0; m_stepping = 0; m_flags = 4'h0;
        end else begin
            go = st && !sp;
            if (STEP_EN) m_stepping = go ? 1'b0 : (m_stepping || stp);
            if (m_phase != 0) begin
                m_pending = m_pending || sp;
                if (m_phase == 3 && d.setflags) m_flags = c;
                if (m_phase < 5)                m_phase++;
                else if (d.hlt)      begin m_phase = 0; m_halted = 1; m_pending = 0; end
                else if (m_pending)  begin m_phase = 0; m_pending = 0; end
                else if (m_stepping) begin m_phase = 0; m_paused = 1; end
                else                 m_phase = 1;
            end else if (m_paused) begin
                if (sp)              m_paused = 0;
                else if (st || stp)  begin m_paused = 0; m_phase = 1; end
            end else if (go) begin
                m_phase = 1; m_halted = 0;
            end
        end
    endtask

    logic [2:0] rec_phase [1:5];
    logic [5:0] rec_str   [1:5];

    // One full instruction starting at P1; ctl = {start,stop,step} pulsed at phase ctl_ph
    task automatic run_instr(input logic [15:0] ir, input logic [3:0] c,
                             input int ctl_ph, input logic [2:0] ctl);
        for (int p = 1; p <= 5; p++) begin
            if (p == ctl_ph) cycle(1, ctl[2], ctl[1], ctl[0], ir, c);
            else             cycle(1, 0, 0, 0, ir, c);
            rec_phase[p] = phase_counter;
            rec_str[p]   = {ir_load, reg_write, mem_read, mem_write, pc_update, branch_taken};
        end
    endtask

    function automatic logic [15:0] rand_ir();
        logic [15:0] r;
        int          nop3 [5] = '{1, 2, 3, 5, 6};
        r = 16'($urandom);
        case ($urandom_range(0, 11))
            0, 1:    begin r[15:14] = 2'b11; r[7:4] = 4'($urandom_range(0, 6)); end
            2:       begin r[15:14] = 2'b11; r[7:4] = 4'($urandom_range(8, 11)); end
            3:       begin r[15:14] = 2'b11; r[7:4] = 4'hC; end
            4:       begin r[15:14] = 2'b11; r[7:4] = 4'hD; end
            5:       begin r[15:14] = 2'b11; r[7:4] = 4'hF; end
            6:       r[15:14] = 2'b00;
            7:       r[15:14] = 2'b01;
            8:       r[15:11] = 5'b10000;
            9:       r[15:11] = 5'b10100;
            10:      r[15:11] = 5'b10111;
            default: begin r[15:14] = 2'b10; r[13:11] = 3'(nop3[$urandom_range(0, 4)]); end
        endcase
        return r;
    endfunction

    initial begin
        int          ph_seq [6] = '{1, 2, 3, 4, 5, 1};
        logic [15:0] cur_ir;
        reset = 1'b0; start = 1'b0; stop = 1'b0; step = 1'b0;
        instruction_register = 16'h0000; cond = 4'h0;

        cycle(0, 0, 0, 0, 16'h0000, 4'h0);
        cycle(0, 0, 0, 0, 16'h0000, 4'h0);
        check_eq("rst_phase", 16'(phase_counter), 16'd0);
        check_eq("rst_flags", 16'(flags), 16'd0);

        // ADD R0,R0 in free run
        cycle(1, 1, 0, 0, 16'hC000, 4'h0);
        for (int i = 0; i < 6; i++) begin
            cycle(1, 0, 0, 0, 16'hC000, 4'h0);
            check_eq("add_phase", 16'(phase_counter), 16'(ph_seq[i]));
            check_eq("add_regwr", 16'(reg_write), 16'(i == 4));
        end
        for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0, 16'hC000, 4'h0);

        // CMP then BE
        run_instr(16'hC050, 4'h4, 0, 3'b000);
        for (int p = 1; p <= 5; p++) check_eq("cmp_regwr", 16'(rec_str[p][4]), 16'd0);
        run_instr(16'hB805, 4'h0, 0, 3'b000);
        check_eq("cmp_flags", 16'(flags), 16'h4);
        check_eq("be_taken", 16'(rec_str[5][0]), 16'd1);

        // ST then LD
        run_instr(16'h4000, 4'h0, 0, 3'b000);
        for (int p = 1; p <= 5; p++) begin
            check_eq("st_memwr", 16'(rec_str[p][2]), 16'(p == 4));
            check_eq("st_regwr", 16'(rec_str[p][4]), 16'd0);
        end
        run_instr(16'h0000, 4'h0, 0, 3'b000);
        check_eq("ld_memrd", 16'(rec_str[4][3]), 16'd1);
        check_eq("ld_regwr", 16'(rec_str[5][4]), 16'd1);

        // reset asserted in P3
        cycle(1, 0, 0, 0, 16'h0000, 4'h0);
        cycle(1, 0, 0, 0, 16'h0000, 4'h0);
        cycle(0, 0, 0, 0, 16'h0000, 4'h0);
        cycle(1, 0, 0, 0, 16'h0000, 4'h0);
        check_eq("rstmid_phase", 16'(phase_counter), 16'd0);
        check_eq("rstmid_flags", 16'(flags), 16'd0);

        // HLT, then restart with a start+stop pulse in P2
        cycle(1, 1, 0, 0, 16'hC0F0, 4'h0);
        run_instr(16'hC0F0, 4'h0, 0, 3'b000);
        check_eq("hlt_pcupd", 16'(rec_str[5][1]), 16'd0);
        cycle(1, 0, 0, 0, 16'hC000, 4'h0);
        check_eq("hlt_halted", 16'(halted), 16'd1);
        check_eq("hlt_phase", 16'(phase_counter), 16'd0);
        cycle(1, 1, 0, 0, 16'hC000, 4'h0);
        run_instr(16'hC000, 4'h0, 2, 3'b110);
        check_eq("restart_p1", 16'(rec_phase[1]), 16'd1);
        check_eq("stop_p5", 16'(rec_phase[5]), 16'd5);
        cycle(1, 0, 0, 0, 16'hC000, 4'h0);
        check_eq("stop_idle", 16'(phase_counter), 16'd0);

        if (STEP_EN) begin
            cycle(1, 1, 0, 0, 16'hC000, 4'h0);
            run_instr(16'hC000, 4'h0, 2, 3'b001);
            cycle(1, 0, 0, 0, 16'hC000, 4'h0);
            check_eq("pause_phase", 16'(phase_counter), 16'd0);
            cycle(1, 0, 0, 1, 16'hC000, 4'h0);
            run_instr(16'hC000, 4'h0, 0, 3'b000);
            check_eq("step_p5", 16'(rec_phase[5]), 16'd5);
            cycle(1, 0, 0, 0, 16'hC000, 4'h0);
            check_eq("step_pause", 16'(phase_counter), 16'd0);
            cycle(1, 1, 0, 0, 16'hC000, 4'h0);
            run_instr(16'hC000, 4'h0, 0, 3'b000);
            cycle(1, 0, 0, 0, 16'hC000, 4'h0);
            check_eq("freerun_p1", 16'(phase_counter), 16'd1);
        end

        // random traffic against the model
        cur_ir = 16'hC000;
        for (int n = 0; n < 4000; n++) begin
            if (m_phase <= 1) cur_ir = rand_ir();
            cycle($urandom_range(0, 149) != 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 29) == 0, $urandom_range(0, 24) == 0,
                  cur_ir, 4'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/phase_sequencer.md
# phase_sequencer

Control sequencer for the 16-bit SIMPLE processor core. It owns the five-phase instruction cycle and the run/stop/halt state, and decodes `instruction_register` into the execute-stage mux and ALU selects and the per-phase write strobes. It also holds the latched `szcv` flag register used for conditional branches. It sits beside fetch, register file, execute and memory stages and drives all of their phase-dependent enables.

## Interface
Parameters:
- `PHASES`, 5: phases per instruction; fixed, values other than 5 unsupported.

Ports:
- `clock`  in  1  system clock.
- `reset`  in  1  synchronous, active-low.
- `start`  in  1  one-cycle pulse; begin or resume execution.
- `stop`  in  1  one-cycle pulse; stop after the current instruction.
- `step`  in  1  one-cycle pulse; advance one instruction in step mode.
- `instruction_register`  in  16  current instruction, valid from P2 onward.
- `cond`  in  4  ALU flags `{S,Z,C,V}`, combinational from execute.
- `phase_counter`  out  3  000 idle, 001 P1 fetch, 010 P2 decode/read, 011 P3 execute, 100 P4 memory, 101 P5 writeback.
- `op_alu_src_a`  out  2  00 `br`(Rd), 01 outside input, 10 PC, 11 zero.
- `op_alu_src_b`  out  2  00 sext imm8, 01 zext imm4, 10 `ar`(Rs), 11 zero.
- `op_alu`  out  4  ALU opcode.
- `op_data_for_output_update`  out  1  OUT instruction decoded.
- `ir_load`, `reg_write`, `mem_read`, `mem_write`, `pc_update`, `branch_taken`  out  1 each  phase strobes.
- `flags`  out  4  latched `{S,Z,C,V}`.
- `running`, `halted`  out  1 each  status.

## Operation
- States: IDLE, RUN, HALTED, and PAUSE (step mode only). Phase advances one per cycle in RUN: P1→P2→P3→P4→P5→P1.
- IDLE/HALTED + `start` → P1 next cycle. `stop` in RUN sets `stop_pending`. At end of P5 with `stop_pending`, go to IDLE and clear the pending bit. `start` and `stop` in the same cycle: `stop` wins.
- Decode classes use `ir[15:14]`.
  - 11 (ALU/IO), `ir[7:4]` selects the op:
    - 0000–0110 (ADD, SUB, AND, OR, XOR, CMP, MOV) → a=00, b=10, `op_alu=ir[7:4]`.
    - 1000–1011 (shifts) → a=00, b=01.
    - 1100 IN → a=01, b=11, ADD.
    - 1101 OUT → `op_data_for_output_update`=1.
    - 1111 HLT.
  - 00 LD, 01 ST → a=00, b=00, ADD.
  - 10 with `ir[13:11]`:
    - 000 LI → a=11, b=00.
    - 100 B → a=10, b=00.
    - 111 Bcc with `ir[10:8]`: 000 BE (Z), 001 BLT (S^V), 010 BLE (Z|(S^V)), 011 BNE (!Z).
  - Any other encoding is a NOP: no writes, PC increments.
- Strobes (combinational, phase-qualified):
  - `ir_load`: P1.
  - `mem_read`: P4 for LD.
  - `mem_write`: P4 for ST.
  - `reg_write`: P5 for ALU ops except CMP, for IN, LD and LI.
  - `pc_update`: P5 always except HLT.
  - `branch_taken`: P5 for B, and for Bcc when its condition holds on `flags`.
- Flags are latched from `cond` at the end of P3, for ALU ops (0000–1011) only.
- HLT: at end of P5 go to HALTED with `halted`=1. A later `start` resumes at P1.
- Outside RUN, all strobes are 0 and `phase_counter`=000.
- `reset` low at any cycle, including mid-instruction, applies reset state next edge. No strobe is asserted in the reset cycle.

## Timing
- Reset values: `phase_counter`=000, `flags`=0000, `running`=0, `halted`=0, `stop_pending`=0, state IDLE. All strobes are 0.
- Latency is 1 cycle from the `start` pulse to P1. Each instruction takes exactly 5 cycles.
- The execute stage latches its data register and output on the edge ending P3 (`phase_counter`=011).
- Mux/ALU selects are combinational from `instruction_register` and stable P2–P5.
- `running`=1 exactly while `phase_counter`≠000.

## Configuration
- `PHASE_SEQUENCER_STEP_EN` defined:
  - When `step` has been seen since the last `start`, the end of P5 enters PAUSE (`phase_counter`=000, `running`=0).
  - Each later `step` pulse runs one instruction. `start` returns to free-run.
  - `stop` in PAUSE goes to IDLE.
- Not defined: `step` ignored, no PAUSE state.

## Structure
- Package `simple_pkg`:
  - phase codes;
  - `src_a`/`src_b` select codes;
  - ALU opcode constants;
  - class/op3/branch-condition constants;
  - state enum.
- One sub-module, `instruction_decoder`: pure combinational IR→selects/class flags. The FSM, flag register and strobe gating stay in `phase_sequencer`.

## Test plan
- Reset, then `start`, IR=`0xC000` (ADD R0,R0) → `phase_counter` 001,010,011,100,101,001. `reg_write` only in 101, `op_alu`=0000, a=00, b=10.
- CMP with `cond`=0100 in P3, then BE (`0xB800`+d) → `flags`=0100, `branch_taken`=1 in P5, `reg_write`=0 throughout.
- ST `0x4000` → `mem_write`=1 only in P4, `reg_write`=0. LD `0x0000` → `mem_read` in P4, `reg_write` in P5.
- HLT `0xC0F0` → after P5 `halted`=1, `phase_counter`=000, `pc_update`=0. `start` → P1 next cycle, `halted`=0.
- `stop` pulse in P2 with `start` asserted same cycle → instruction completes P5, then IDLE.
- `reset` low during P3 → next cycle `phase_counter`=000 and `flags`=0000. With `PHASE_SEQUENCER_STEP_EN`, `step` pulses advance exactly one 5-cycle instruction each.
